barrel_shifter_8b: RTL and testbench

//  - 8-bit logarithmic barrel shifter with a registered output.
//  - Shifts the 8-bit operand by 0..7 positions, selected by a 3-bit control.
//  - Default operation is a logical right shift: zero fill, no rotation.
//  - Datapath utility block; feeds ALU or formatting logic that can absorb one cycle of latency.

---
 rtl/barrel_shifter_8b_pkg.sv | 27 ++
 rtl/barrel_shifter_8b_stage.sv | 34 +++
 rtl/barrel_shifter_8b.sv | 48 ++++
 tb/tb_barrel_shifter_8b.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_8b_pkg.sv
// Shared shifter definitions. Other shifter users import the mode enum from here.
//   DATA_W       operand / result width
//   SHAMT_W      shift-amount width (one mux stage per bit)
//   shift_mode_e LSR / LSL / ROR / ROL
//   mode_of()    maps the ROTATE / SHIFT_LEFT parameter pair onto a mode
package barrel_shifter_8b_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic [1:0] {
    LSR = 2'd0,
    LSL = 2'd1,
    ROR = 2'd2,
    ROL = 2'd3
  } shift_mode_e;

  function automatic shift_mode_e mode_of(input bit rotate, input bit left);
    case ({rotate, left})
      2'b00:   return LSR;
      2'b01:   return LSL;
      2'b10:   return ROR;
      default: return ROL;
    endcase
  endfunction

endpackage

// File: rtl/barrel_shifter_8b_stage.sv
// One stage of the logarithmic shifter: shifts/rotates by a fixed AMOUNT
// when sel is high, otherwise passes the operand through. Purely combinational.
//   in   operand from the previous stage
//   sel  one bit of the shift amount
//   out  operand for the next stage
module barrel_stage
  import barrel_shifter_8b_pkg::*;
#(
  parameter int AMOUNT     = 1,
  parameter bit ROTATE     = 1'b0,
  parameter bit SHIFT_LEFT = 1'b0
) (
  input  logic [DATA_W-1:0] in,
  input  logic              sel,
  output logic [DATA_W-1:0] out
);

  localparam shift_mode_e MODE = mode_of(ROTATE, SHIFT_LEFT);

  logic [DATA_W-1:0] shf;

  // Rotations OR in the bits that a plain shift would drop off the far end.
  always_comb begin
    case (MODE)
      LSR:     shf = in >> AMOUNT;
      LSL:     shf = in << AMOUNT;
      ROR:     shf = (in >> AMOUNT) | (in << (DATA_W - AMOUNT));
      default: shf = (in << AMOUNT) | (in >> (DATA_W - AMOUNT));
    endcase
  end

  assign out = sel ? shf : in;

endmodule

// File: rtl/barrel_shifter_8b.sv
// 8-bit logarithmic barrel shifter, one cycle latency, new operand every cycle.
//   clk    rising-edge clock
//   rst_n  async active-low reset, clears out
//   in     operand
//   ctrl   shift amount 0..7
//   out    registered result
// ROTATE=1 wraps shifted-out bits; SHIFT_LEFT=1 shifts toward the MSB.
module barrel_shifter_8b
  import barrel_shifter_8b_pkg::*;
#(
  parameter bit ROTATE     = 1'b0,
  parameter bit SHIFT_LEFT = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] ctrl,
  output logic [DATA_W-1:0]  out
);

  // stg[i] is the operand after stages 0..i-1; stage i shifts by 2**i.
  logic [DATA_W-1:0] stg [SHAMT_W+1];
  logic [DATA_W-1:0] out_d, out_q;

  assign stg[0] = in;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stg
    barrel_stage #(
      .AMOUNT     (1 << i),
      .ROTATE     (ROTATE),
      .SHIFT_LEFT (SHIFT_LEFT)
    ) u_stg (
      .in  (stg[i]),
      .sel (ctrl[i]),
      .out (stg[i+1])
    );
  end

  assign out_d = stg[SHAMT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: tb/tb_barrel_shifter_8b.sv
// Self-checking bench: one DUT per mode (LSR, LSL, ROR, ROL) driven in parallel,
// checked every cycle against a reference built from {in,in} arithmetic, plus
// hand-computed literal expectations.
module tb_barrel_shifter_8b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] ctrl = 3'd0;
  logic [7:0] dout [4];

  always #5 clk = ~clk;

  barrel_shifter_8b #(.ROTATE(1'b0), .SHIFT_LEFT(1'b0)) u_lsr
    (.clk(clk), .rst_n(rst_n), .in(din), .ctrl(ctrl), .out(dout[0]));
  barrel_shifter_8b #(.ROTATE(1'b0), .SHIFT_LEFT(1'b1)) u_lsl
    (.clk(clk), .rst_n(rst_n), .in(din), .ctrl(ctrl), .out(dout[1]));
  barrel_shifter_8b #(.ROTATE(1'b1), .SHIFT_LEFT(1'b0)) u_ror
    (.clk(clk), .rst_n(rst_n), .in(din), .ctrl(ctrl), .out(dout[2]));
  barrel_shifter_8b #(.ROTATE(1'b1), .SHIFT_LEFT(1'b1)) u_rol
    (.clk(clk), .rst_n(rst_n), .in(din), .ctrl(ctrl), .out(dout[3]));

  // Reference: rotations read a window out of the doubled operand.
  function automatic logic [7:0] ref_f(input int m, input logic [7:0] a, input logic [2:0] c);
    logic [15:0] d;
    d = {a, a};
    case (m)
      0:       return a >> c;
      1:       begin d = 16'(a) << c; return d[7:0]; end
      2:       begin d = d >> c;      return d[7:0]; end
      default: begin d = d << c;      return d[15:8]; end
    endcase
  endfunction

  // Expected registered outputs: previous edge's inputs, zero while in reset.
  logic [7:0] exp_q [4];
  logic [1:0] vld_pipe = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 4; m++) exp_q[m] <= 8'h00;
    end else begin
      for (int m = 0; m < 4; m++) exp_q[m] <= ref_f(m, din, ctrl);
    end
  end

  always @(posedge clk) vld_pipe <= {vld_pipe[0], 1'b1};

  // Literal expectation, applied to DUT lit_m at the next compare.
  logic       lit_en = 1'b0;
  int         lit_m  = 0;
  logic [7:0] lit_v  = 8'h00;
  string      lit_nm = "";

  int n_checks = 0;
  int n_errs   = 0;

  // Single compare process: mid-cycle on negedge clk, and 1 ns after any reset assertion.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (vld_pipe[0] || !rst_n) begin
      for (int m = 0; m < 4; m++) begin
        n_checks++;
        if (dout[m] !== exp_q[m]) begin
          n_errs++;
          $display("FAIL model mode%0d t=%0t in=%h ctrl=%0d rst_n=%b: got %h want %h",
                   m, $time, din, ctrl, rst_n, dout[m], exp_q[m]);
        end
      end
      if (lit_en) begin
        n_checks++;
        if (dout[lit_m] !== lit_v) begin
          n_errs++;
          $display("FAIL %s mode%0d: got %h want %h", lit_nm, lit_m, dout[lit_m], lit_v);
        end
      end
    end
  end

  task automatic directed(input string nm, input int m, input logic [7:0] a,
                          input logic [2:0] c, input logic [7:0] e);
    @(posedge clk); #2;
    lit_en = 1'b0;
    din = a; ctrl = c;
    @(posedge clk); #2;
    lit_nm = nm; lit_m = m; lit_v = e; lit_en = 1'b1;
  endtask

  initial begin
    // Reset held with a nonzero operand: output must stay clear.
    rst_n = 1'b0; din = 8'hFF; ctrl = 3'd3;
    repeat (2) @(posedge clk);
    #2;
    lit_nm = "reset_hold"; lit_m = 0; lit_v = 8'h00; lit_en = 1'b1;
    @(posedge clk); #2;
    lit_en = 1'b0;
    rst_n = 1'b1;

    directed("lsr_zero",   0, 8'd0,   3'd0, 8'd0);
    directed("lsr_128_4",  0, 8'd128, 3'd4, 8'd8);
    directed("lsr_128_2",  0, 8'd128, 3'd2, 8'd32);
    directed("lsr_128_1",  0, 8'd128, 3'd1, 8'd64);
    directed("lsr_255_7",  0, 8'd255, 3'd7, 8'd1);
    directed("lsl_ff_7",   1, 8'hFF,  3'd7, 8'h80);
    directed("lsl_01_3",   1, 8'h01,  3'd3, 8'h08);
    directed("ror_81_1",   2, 8'h81,  3'd1, 8'hC0);
    directed("ror_ff_7",   2, 8'hFF,  3'd7, 8'hFF);
    directed("ror_01_7",   2, 8'h01,  3'd7, 8'h02);
    directed("rol_81_1",   3, 8'h81,  3'd1, 8'h03);
    directed("rol_80_7",   3, 8'h80,  3'd7, 8'h40);
    directed("lsr_pass",   0, 8'hA5,  3'd0, 8'hA5);
    directed("rol_pass",   3, 8'hA5,  3'd0, 8'hA5);

    // Back-to-back random operands: model only matches if latency is exactly one.
    @(posedge clk); #2;
    lit_en = 1'b0;
    repeat (16) begin
      din = 8'($urandom); ctrl = 3'($urandom_range(7));
      @(posedge clk); #2;
    end

    // Async reset asserted mid-cycle, with a nonzero result captured.
    din = 8'hF0; ctrl = 3'd0;
    @(posedge clk); #2;
    lit_nm = "async_rst"; lit_m = 0; lit_v = 8'h00; lit_en = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #2;
    din = 8'h3C; ctrl = 3'd2;
    #4 rst_n = 1'b1;  // released mid-cycle, first value after next edge
    @(posedge clk); #2;
    lit_nm = "post_release"; lit_m = 0; lit_v = 8'h0F; lit_en = 1'b1;

    // Exhaustive sweep in every mode, in randomised order of start operand.
    begin
      int base;
      base = int'($urandom_range(255));
      @(posedge clk); #2;
      lit_en = 1'b0;
      for (int i = 0; i < 256; i++) begin
        for (int c = 0; c < 8; c++) begin
          din = 8'((base + i) % 256); ctrl = 3'(c);
          @(posedge clk); #2;
        end
      end
    end

    // Random stream with occasional reset pulses.
    repeat (300) begin
      din = 8'($urandom); ctrl = 3'($urandom_range(7));
      if ($urandom_range(40) == 0) begin
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      @(posedge clk); #2;
    end

    @(negedge clk); #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
